// File: rtl/alu_div_pkg.sv
// Shared definitions for the ALU divider: op encodings, FSM states and default width.
package alu_div_pkg;

   localparam int unsigned XLEN_DEF = 32;

   typedef enum logic [1:0] {
      ALU_DIV  = 2'b00,
      ALU_DIVU = 2'b01,
      ALU_REM  = 2'b10,
      ALU_REMU = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } div_state_e;

endpackage

// File: rtl/alu_div_if.sv
// Valid/ready request and response channels between the execute stage and the divider.
interface alu_div_if
   import alu_div_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
);
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      op;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] rd;

   modport master (
      output in_valid, op, rs1, rs2, out_ready,
      input  in_ready, out_valid, rd
   );

   modport slave (
      input  in_valid, op, rs1, rs2, out_ready,
      output in_ready, out_valid, rd
   );
endinterface

// File: rtl/alu_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module alu_div_step
   import alu_div_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] divisor,
   input  logic            din,
   output logic [XLEN-1:0] rem_c,
   output logic            qbit_c
);
   logic [XLEN:0] trial;
   logic [XLEN:0] diff;

   // The trial keeps the bit shifted out of rem so divisors with the MSB set compare correctly.
   assign trial  = {rem, din};
   assign diff   = trial - {1'b0, divisor};
   assign qbit_c = ~diff[XLEN];
   assign rem_c  = qbit_c ? diff[XLEN-1:0] : trial[XLEN-1:0];
endmodule

// File: rtl/alu_div.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
module alu_div
   import alu_div_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
) (
   input  logic clk,
   input  logic reset,
   alu_div_if.slave bus
);
   localparam int unsigned CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

   function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
      return (~x) + XLEN'(1);
   endfunction

   div_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] dvd_q, dvd_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] dsr_q, dsr_d;
   logic            qsign_q, qsign_d;
   logic            rsign_q, rsign_d;
   logic            sel_rem_q, sel_rem_d;
   logic [XLEN-1:0] rd_q, rd_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;

   logic            is_signed, s1, s2, div0, ovf, last;
   logic [XLEN-1:0] abs1, abs2, step_rem, q_fin, r_fin;
   logic            step_q;

   // Operand decode used only on the accept edge.
   assign is_signed = ~bus.op[0];
   assign s1        = is_signed & bus.rs1[XLEN-1];
   assign s2        = is_signed & bus.rs2[XLEN-1];
   assign abs1      = s1 ? neg(bus.rs1) : bus.rs1;
   assign abs2      = s2 ? neg(bus.rs2) : bus.rs2;
   assign div0      = (bus.rs2 == '0);
   assign ovf       = is_signed & (bus.rs1 == SMIN) & (&bus.rs2);
   assign last      = (cnt_q == CW'(XLEN - 1));

   alu_div_step #(.XLEN(XLEN)) u_step (
      .rem     (rem_q),
      .divisor (dsr_q),
      .din     (dvd_q[XLEN-1]),
      .rem_c   (step_rem),
      .qbit_c  (step_q)
   );

   // Quotient bits shift into the vacated low end of the dividend register.
   assign q_fin = qsign_q ? neg({dvd_q[XLEN-2:0], step_q}) : {dvd_q[XLEN-2:0], step_q};
   assign r_fin = rsign_q ? neg(step_rem) : step_rem;

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (bus.in_valid) state_d = (div0 || ovf) ? ST_DONE : ST_BUSY;
         ST_BUSY: if (last)         state_d = ST_DONE;
         ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
         default:                   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      dvd_d       = dvd_q;
      rem_d       = rem_q;
      dsr_d       = dsr_q;
      qsign_d     = qsign_q;
      rsign_d     = rsign_q;
      sel_rem_d   = sel_rem_q;
      rd_d        = rd_q;
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
      unique case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               cnt_d     = '0;
               rem_d     = '0;
               dvd_d     = abs1;
               dsr_d     = abs2;
               qsign_d   = s1 ^ s2;
               rsign_d   = s1;
               sel_rem_d = bus.op[1];
               if (div0)     rd_d = bus.op[1] ? bus.rs1 : '1;
               else if (ovf) rd_d = bus.op[1] ? '0 : SMIN;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q + CW'(1);
            dvd_d = {dvd_q[XLEN-2:0], step_q};
            rem_d = step_rem;
            if (last) rd_d = sel_rem_q ? r_fin : q_fin;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         dvd_q       <= '0;
         rem_q       <= '0;
         dsr_q       <= '0;
         qsign_q     <= 1'b0;
         rsign_q     <= 1'b0;
         sel_rem_q   <= 1'b0;
         rd_q        <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         dvd_q       <= dvd_d;
         rem_q       <= rem_d;
         dsr_q       <= dsr_d;
         qsign_q     <= qsign_d;
         rsign_q     <= rsign_d;
         sel_rem_q   <= sel_rem_d;
         rd_q        <= rd_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.rd        = rd_q;
endmodule

// File: tb/tb_alu_div.sv
// Self-checking bench for alu_div: vector table, random ops against a reference model, and handshake/reset corners.
module tb_alu_div;
   import alu_div_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   logic [31:0] exp_q[$];

   alu_div_if #(.XLEN(32)) bus ();
   alu_div #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
      case (op)
         2'b00:   return 32'($signed(a) / $signed(b));
         2'b01:   return a / b;
         2'b10:   return 32'($signed(a) % $signed(b));
         default: return a % b;
      endcase
   endfunction

   // Latency counts edges from the accept edge (edge 1) until out_valid is seen.
   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      int n;
      logic [31:0] e;
      @(posedge clk); #1;
      chk({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.op  = op;
      bus.rs1 = a;
      bus.rs2 = b;
      exp_q.push_back(exp);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n = 1;
      while (!bus.out_valid && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, " latency"}, 32'(n), 32'(lat));
      if (exp_q.size() == 0) chk({name, " scoreboard"}, 32'd0, 32'd1);
      else begin
         e = exp_q.pop_front();
         chk({name, " rd"}, bus.rd, e);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk({name, " release"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
   endtask

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      int          seen;

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op        = 2'b00;
      bus.rs1       = '0;
      bus.rs2       = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("reset state", {bus.rd[29:0], bus.out_valid, bus.in_ready}, 32'd1);

      vecs.push_back(vec_t'{ALU_DIVU, 32'd100,        32'd7,          32'd14,         33});
      vecs.push_back(vec_t'{ALU_REMU, 32'd100,        32'd7,          32'd2,          33});
      vecs.push_back(vec_t'{ALU_DIV,  32'hFFFF_FFB9,  32'd8,          32'hFFFF_FFF8,  33});
      vecs.push_back(vec_t'{ALU_REM,  32'hFFFF_FFB9,  32'd8,          32'hFFFF_FFF9,  33});
      vecs.push_back(vec_t'{ALU_DIV,  32'd71,         32'hFFFF_FFAE,  32'd0,          33});
      vecs.push_back(vec_t'{ALU_REM,  32'd71,         32'hFFFF_FFAE,  32'd71,         33});
      vecs.push_back(vec_t'{ALU_DIV,  32'd71,         32'd0,          32'hFFFF_FFFF,  1});
      vecs.push_back(vec_t'{ALU_REMU, 32'd71,         32'd0,          32'd71,         1});
      vecs.push_back(vec_t'{ALU_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1});
      vecs.push_back(vec_t'{ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
      vecs.push_back(vec_t'{ALU_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
      vecs.push_back(vec_t'{ALU_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33});
      vecs.push_back(vec_t'{ALU_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33});
      vecs.push_back(vec_t'{ALU_DIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          33});
      vecs.push_back(vec_t'{ALU_REMU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          33});
      vecs.push_back(vec_t'{ALU_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33});
      vecs.push_back(vec_t'{ALU_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         33});
      vecs.push_back(vec_t'{ALU_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  33});
      vecs.push_back(vec_t'{ALU_DIVU, 32'h1234_5678,  32'h0000_1000,  32'h0001_2345,  33});
      vecs.push_back(vec_t'{ALU_REMU, 32'h1234_5678,  32'h0000_1000,  32'h0000_0678,  33});

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

      for (int i = 0; i < 8; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom >> $urandom_range(0, 31);
         run_op($sformatf("rand%0d", i), rop, ra, rb, ref_div(rop, ra, rb),
                (rb == 32'd0 || (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? 1 : 33);
      end

      // Backpressure: result held while out_ready is low and new requests are offered.
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.op = ALU_DIVU; bus.rs1 = 32'd100; bus.rs2 = 32'd7;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      seen = 0;
      while (!bus.out_valid && seen < 60) begin @(posedge clk); #1; seen++; end
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = ~bus.in_valid;
         bus.rs1 = $urandom; bus.rs2 = $urandom; bus.op = 2'($urandom_range(0, 3));
         chk($sformatf("bp hold %0d", i), {bus.rd[29:0], bus.out_valid, bus.in_ready}, {30'd14, 2'b10});
         @(posedge clk); #1;
      end
      chk("bp still held", {bus.rd[29:0], bus.out_valid, bus.in_ready}, {30'd14, 2'b10});
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("bp release", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);

      // Reset during the 10th BUSY cycle discards the operation.
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.op = ALU_DIVU; bus.rs1 = 32'd100; bus.rs2 = 32'd7;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mid reset state", {bus.rd[29:0], bus.out_valid, bus.in_ready}, 32'd1);
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (bus.out_valid) seen++; end
      chk("mid reset no result", 32'(seen), 32'd0);
      run_op("post reset", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33);

      // Reset coinciding with an accept drops the request.
      @(posedge clk); #1;
      reset = 1'b1;
      bus.in_valid = 1'b1; bus.op = ALU_DIV; bus.rs1 = 32'd71; bus.rs2 = 32'd0;
      @(posedge clk); #1;
      reset = 1'b0;
      bus.in_valid = 1'b0;
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (bus.out_valid || !bus.in_ready) seen++; end
      chk("reset beats accept", 32'(seen), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
